// File: rtl/palette_lut_fade.sv
// Run-time writable colour palette with a two-stage lookup pipeline and a global
// brightness fader used for fade-to-black / fade-in level transitions.
module palette_lut_fade #(
    parameter int INDEX_W    = 4,
    parameter int COLOR_W    = 4,
    parameter int FADE_SHIFT = 4,
    parameter int FADE_DIV   = 2,
    parameter logic [(2**INDEX_W)*3*COLOR_W-1:0] INIT_PAL = '0
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   pix_valid_i,
    input  logic [INDEX_W-1:0]     index_i,
    input  logic                   wr_en_i,
    input  logic [INDEX_W-1:0]     wr_addr_i,
    input  logic [3*COLOR_W-1:0]   wr_data_i,
    input  logic                   frame_tick_i,
    input  logic                   fade_start_i,
    input  logic                   fade_dir_i,
    output logic [COLOR_W-1:0]     red_o,
    output logic [COLOR_W-1:0]     green_o,
    output logic [COLOR_W-1:0]     blue_o,
    output logic                   rgb_valid_o,
    output logic                   fade_busy_o,
    output logic                   fade_done_o
);
    localparam int ENTRIES = 2**INDEX_W;
    localparam int RGB_W   = 3*COLOR_W;
    localparam int LVL_W   = FADE_SHIFT + 1;
    localparam int PROD_W  = COLOR_W + FADE_SHIFT + 1;
    localparam int DIV_W   = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [LVL_W-1:0] MAX_LVL  = LVL_W'(1 << FADE_SHIFT);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FADE_DIV - 1);

    typedef enum logic [0:0] {StIdle, StFading} state_e;

    logic [RGB_W-1:0]   ram_q [ENTRIES];
    logic [RGB_W-1:0]   s1_rgb_q, s1_rgb_d;
    logic               s1_vld_q;
    logic [COLOR_W-1:0] red_q, green_q, blue_q;
    logic               vld_q;

    state_e             state_q, state_d;
    logic [LVL_W-1:0]   level_q, level_d, target;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               dir_q, dir_d;
    logic               done_q, done_d;

    function automatic logic [COLOR_W-1:0] scale(input logic [COLOR_W-1:0] c,
                                                 input logic [LVL_W-1:0]   l);
        logic [PROD_W-1:0] p;
        p = PROD_W'(c) * PROD_W'(l);
        return p[FADE_SHIFT +: COLOR_W];
    endfunction

    // Write-first bypass so a same-cycle lookup of the written entry sees new data.
    always_comb begin
        s1_rgb_d = ram_q[index_i];
        if (wr_en_i && (wr_addr_i == index_i)) begin
            s1_rgb_d = wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ram_q[i] <= INIT_PAL[i*RGB_W +: RGB_W];
            end
            s1_rgb_q <= '0;
            s1_vld_q <= 1'b0;
            red_q    <= '0;
            green_q  <= '0;
            blue_q   <= '0;
            vld_q    <= 1'b0;
        end else begin
            if (wr_en_i) begin
                ram_q[wr_addr_i] <= wr_data_i;
            end
            s1_rgb_q <= s1_rgb_d;
            s1_vld_q <= pix_valid_i;
            red_q    <= scale(s1_rgb_q[RGB_W-1 -: COLOR_W], level_q);
            green_q  <= scale(s1_rgb_q[2*COLOR_W-1 -: COLOR_W], level_q);
            blue_q   <= scale(s1_rgb_q[COLOR_W-1:0], level_q);
            vld_q    <= s1_vld_q;
        end
    end

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        div_d   = div_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        target  = dir_q ? MAX_LVL : LVL_W'(0);
        if (fade_start_i) begin
            // A restart overrides any concurrent frame tick and abandons the old fade silently.
            dir_d = fade_dir_i;
            div_d = '0;
            if (level_q == (fade_dir_i ? MAX_LVL : LVL_W'(0))) begin
                state_d = StIdle;
                done_d  = 1'b1;
            end else begin
                state_d = StFading;
            end
        end else if ((state_q == StFading) && frame_tick_i) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
                if (level_q != target) begin
                    level_d = dir_q ? level_q + 1'b1 : level_q - 1'b1;
                end
                if (level_d == target) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            level_q <= MAX_LVL;
            div_q   <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            div_q   <= div_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
        end
    end

    assign red_o       = red_q;
    assign green_o     = green_q;
    assign blue_o      = blue_q;
    assign rgb_valid_o = vld_q;
    assign fade_busy_o = (state_q == StFading);
    assign fade_done_o = done_q;

endmodule
